// File: rtl/hier_resp_collector_if.sv
// Child fan-in and parent response bus for hier_resp_collector.
// With HIER_COLLECT_PARITY_EN defined, the bus also carries per-child parity and the parent parity bit.
interface hier_resp_collector_if #(
    parameter int unsigned NUM_CHILD = 5,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDX_W     = 3
) ();
    logic [NUM_CHILD-1:0]        child_valid;
    logic [NUM_CHILD*DATA_W-1:0] child_data;
    logic [NUM_CHILD-1:0]        child_ready;
    logic                        par_valid;
    logic [DATA_W-1:0]           par_data;
    logic [IDX_W-1:0]            par_idx;
    logic                        par_ready;
`ifdef HIER_COLLECT_PARITY_EN
    logic [NUM_CHILD-1:0]        child_parity;
    logic                        par_parity;

    // Collector side: accepts child beats, drives the parent response.
    modport master (
        input  child_valid, child_data, child_parity, par_ready,
        output child_ready, par_valid, par_data, par_idx, par_parity
    );

    // Environment side: the children and the parent.
    modport slave (
        output child_valid, child_data, child_parity, par_ready,
        input  child_ready, par_valid, par_data, par_idx, par_parity
    );
`else
    // Collector side: accepts child beats, drives the parent response.
    modport master (
        input  child_valid, child_data, par_ready,
        output child_ready, par_valid, par_data, par_idx
    );

    // Environment side: the children and the parent.
    modport slave (
        output child_valid, child_data, par_ready,
        input  child_ready, par_valid, par_data, par_idx
    );
`endif
endinterface

// File: rtl/hier_resp_collector.sv
// Round-robin fan-in of NUM_CHILD child response streams into one registered
// parent valid/ready stream tagged with the source child index.
// Optional feature macro: HIER_COLLECT_PARITY_EN (parent parity bit, sticky parity error).
module hier_resp_collector #(
    parameter int unsigned NUM_CHILD = 5,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hier_resp_collector_if.master bus,
    output logic [CNT_W-1:0]     resp_count,
    output logic                 busy
`ifdef HIER_COLLECT_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned SEL_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CHILD - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state;
    logic [SEL_W-1:0]     rr_ptr;
    logic [DATA_W-1:0]    out_data;
    logic [IDX_W-1:0]     out_idx;
    logic [DATA_W-1:0]    child_word [NUM_CHILD];
    logic                 grant_vld;
    logic [SEL_W-1:0]     grant_sel;
    logic [SEL_W-1:0]     next_ptr;
    logic                 load_en;
    logic                 load;
    logic [NUM_CHILD-1:0] ready;

    // Unpack the flat child payload bus into one word per child.
    for (genvar k = 0; k < NUM_CHILD; k++) begin : g_unpack
        assign child_word[k] = bus.child_data[k*DATA_W +: DATA_W];
    end

    assign load_en  = (state == EMPTY) || bus.par_ready;
    assign load     = load_en && grant_vld;
    assign next_ptr = (grant_sel == LAST_SEL) ? '0 : grant_sel + 1'b1;

    // Round-robin scan starting at rr_ptr; the first valid child wins.
    always_comb begin
        int unsigned pos;
        grant_vld = 1'b0;
        grant_sel = '0;
        pos       = 0;
        for (int unsigned i = 0; i < NUM_CHILD; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= NUM_CHILD) begin
                pos = pos - NUM_CHILD;
            end
            if (!grant_vld && bus.child_valid[SEL_W'(pos)]) begin
                grant_vld = 1'b1;
                grant_sel = SEL_W'(pos);
            end
        end
    end

    // One-hot accept to the granted child; suppressed during reset.
    always_comb begin
        ready = '0;
        if (rst_n && load) begin
            ready[grant_sel] = 1'b1;
        end
    end

    // Output register: load replaces (or fills) the beat, drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_idx  <= '0;
            rr_ptr   <= '0;
        end else begin
            if (load) begin
                state    <= FULL;
                out_data <= child_word[grant_sel];
                out_idx  <= IDX_W'(grant_sel);
                rr_ptr   <= next_ptr;
            end else if (state == FULL && bus.par_ready) begin
                state <= EMPTY;
            end
        end
    end

    // Saturating count of completed parent handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_count <= '0;
        end else if (state == FULL && bus.par_ready && resp_count != CNT_MAX) begin
            resp_count <= resp_count + 1'b1;
        end
    end

`ifdef HIER_COLLECT_PARITY_EN
    logic out_parity;

    // Parent parity tracks the loaded beat; mismatching child parity sets a sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
            parity_err <= 1'b0;
        end else if (load) begin
            out_parity <= ^{child_word[grant_sel], IDX_W'(grant_sel)};
            if (bus.child_parity[grant_sel] != ^{child_word[grant_sel], IDX_W'(grant_sel)}) begin
                parity_err <= 1'b1;
            end
        end
    end

    assign bus.par_parity = out_parity;
`endif

    assign bus.child_ready = ready;
    assign bus.par_valid   = (state == FULL);
    assign bus.par_data    = out_data;
    assign bus.par_idx     = out_idx;
    assign busy            = (state == FULL) || (|bus.child_valid);

endmodule

// File: tb/tb_hier_resp_collector.sv
// Directed bench for hier_resp_collector: reset, fairness, backpressure,
// wrap/skip arbitration, counter saturation and (when enabled) parity.
module tb_hier_resp_collector;

    logic        clk;
    logic        rst_n;
    logic [15:0] resp_count;
    logic        busy;
    logic [2:0]  resp_count_sat;
    logic        busy_sat;
    int          total;
    int          bad;

    hier_resp_collector_if #(.NUM_CHILD(5), .DATA_W(8), .IDX_W(3)) bus ();
    hier_resp_collector_if #(.NUM_CHILD(5), .DATA_W(8), .IDX_W(3)) bus_sat ();

`ifdef HIER_COLLECT_PARITY_EN
    logic parity_err;
    logic parity_err_sat;

    hier_resp_collector #(.NUM_CHILD(5), .DATA_W(8), .IDX_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .resp_count(resp_count), .busy(busy), .parity_err(parity_err)
    );
    hier_resp_collector #(.NUM_CHILD(5), .DATA_W(8), .IDX_W(3), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_sat.master),
        .resp_count(resp_count_sat), .busy(busy_sat), .parity_err(parity_err_sat)
    );
`else
    hier_resp_collector #(.NUM_CHILD(5), .DATA_W(8), .IDX_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .resp_count(resp_count), .busy(busy)
    );
    hier_resp_collector #(.NUM_CHILD(5), .DATA_W(8), .IDX_W(3), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_sat.master),
        .resp_count(resp_count_sat), .busy(busy_sat)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.child_valid = 5'b11111;
        bus.par_ready   = 1'b0;
        repeat (3) tick();
        total++; if (bus.child_ready !== 5'b00000) begin bad++; $display("FAIL rst_child_ready got=%b exp=00000", bus.child_ready); end
        total++; if (bus.par_valid !== 1'b0) begin bad++; $display("FAIL rst_par_valid got=%b exp=0", bus.par_valid); end
        total++; if (resp_count !== 16'd0) begin bad++; $display("FAIL rst_resp_count got=%0d exp=0", resp_count); end
        total++; if (bus.par_data !== 8'h00) begin bad++; $display("FAIL rst_par_data got=%h exp=00", bus.par_data); end
        total++; if (bus.par_idx !== 3'd0) begin bad++; $display("FAIL rst_par_idx got=%0d exp=0", bus.par_idx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
        rst_n = 1'b1;
        #1;
        total++; if (bus.child_ready !== 5'b00001) begin bad++; $display("FAIL rel_first_grant got=%b exp=00001", bus.child_ready); end
        tick();
        total++; if (bus.par_valid !== 1'b1) begin bad++; $display("FAIL rel_par_valid got=%b exp=1", bus.par_valid); end
        total++; if (bus.par_idx !== 3'd0) begin bad++; $display("FAIL rel_par_idx got=%0d exp=0", bus.par_idx); end
        total++; if (bus.par_data !== 8'h10) begin bad++; $display("FAIL rel_par_data got=%h exp=10", bus.par_data); end
        total++; if (bus.child_ready !== 5'b00000) begin bad++; $display("FAIL rel_full_stall got=%b exp=00000", bus.child_ready); end
        bus.child_valid = 5'b00000;
        bus.par_ready   = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_fairness();
        do_reset();
        bus.child_valid = 5'b11111;
        bus.par_ready   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (bus.par_idx !== 3'(i % 5)) begin bad++; $display("FAIL fair_idx[%0d] got=%0d exp=%0d", i, bus.par_idx, i % 5); end
            total++; if (bus.par_data !== 8'(8'h10 + i % 5)) begin bad++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, bus.par_data, 8'(8'h10 + i % 5)); end
            total++; if (resp_count !== 16'(i)) begin bad++; $display("FAIL fair_count[%0d] got=%0d exp=%0d", i, resp_count, i); end
        end
        bus.child_valid = 5'b00000;
        tick();
        total++; if (resp_count !== 16'd6) begin bad++; $display("FAIL fair_final_count got=%0d exp=6", resp_count); end
        total++; if (bus.par_valid !== 1'b0) begin bad++; $display("FAIL fair_drain got=%b exp=0", bus.par_valid); end
    endtask

    task automatic test_backpressure();
        bus.child_data[2*8 +: 8] = 8'hA5;
        bus.child_valid = 5'b00100;
        bus.par_ready   = 1'b0;
        #1;
        total++; if (bus.child_ready !== 5'b00100) begin bad++; $display("FAIL bp_grant got=%b exp=00100", bus.child_ready); end
        tick();
        bus.child_valid = 5'b00001;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++; if (bus.par_data !== 8'hA5) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=a5", c, bus.par_data); end
            total++; if (bus.par_idx !== 3'd2) begin bad++; $display("FAIL bp_idx[%0d] got=%0d exp=2", c, bus.par_idx); end
            total++; if (bus.child_ready !== 5'b00000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=00000", c, bus.child_ready); end
            total++; if (resp_count !== 16'd6) begin bad++; $display("FAIL bp_count[%0d] got=%0d exp=6", c, resp_count); end
            tick();
        end
        bus.par_ready = 1'b1;
        #1;
        total++; if (bus.child_ready !== 5'b00001) begin bad++; $display("FAIL bp_release_grant got=%b exp=00001", bus.child_ready); end
        tick();
        total++; if (resp_count !== 16'd7) begin bad++; $display("FAIL bp_single_hs got=%0d exp=7", resp_count); end
        total++; if (bus.par_idx !== 3'd0) begin bad++; $display("FAIL bp_next_idx got=%0d exp=0", bus.par_idx); end
        bus.child_valid = 5'b00000;
        tick();
        total++; if (resp_count !== 16'd8) begin bad++; $display("FAIL bp_end_count got=%0d exp=8", resp_count); end
        total++; if (bus.par_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b exp=0", bus.par_valid); end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        bus.par_ready   = 1'b1;
        bus.child_valid = 5'b01000;
        tick();
        bus.child_valid = 5'b00000;
        tick();
        bus.child_valid = 5'b01010;
        #1;
        total++; if (bus.child_ready !== 5'b00010) begin bad++; $display("FAIL wrap_first got=%b exp=00010", bus.child_ready); end
        tick();
        total++; if (bus.par_idx !== 3'd1) begin bad++; $display("FAIL wrap_idx1 got=%0d exp=1", bus.par_idx); end
        total++; if (bus.par_data !== 8'h11) begin bad++; $display("FAIL wrap_data1 got=%h exp=11", bus.par_data); end
        bus.child_valid = 5'b01000;
        #1;
        total++; if (bus.child_ready !== 5'b01000) begin bad++; $display("FAIL wrap_second got=%b exp=01000", bus.child_ready); end
        tick();
        total++; if (bus.par_idx !== 3'd3) begin bad++; $display("FAIL wrap_idx3 got=%0d exp=3", bus.par_idx); end
        total++; if (bus.par_data !== 8'h13) begin bad++; $display("FAIL wrap_data3 got=%h exp=13", bus.par_data); end
        bus.child_valid = 5'b00000;
        tick();
        bus.child_valid = 5'b10001;
        #1;
        total++; if (bus.child_ready !== 5'b10000) begin bad++; $display("FAIL wrap_ptr_end got=%b exp=10000", bus.child_ready); end
        bus.child_valid = 5'b00000;
        tick();
    endtask

    task automatic test_saturation();
        bus_sat.child_valid = 5'b00001;
        bus_sat.par_ready   = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            total++; if (resp_count_sat !== 3'((e - 1 > 7) ? 7 : e - 1)) begin bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", e, resp_count_sat, (e - 1 > 7) ? 7 : e - 1); end
        end
        bus_sat.child_valid = 5'b00000;
        tick();
        total++; if (resp_count_sat !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d exp=7", resp_count_sat); end
    endtask

`ifdef HIER_COLLECT_PARITY_EN
    task automatic test_parity();
        do_reset();
        bus.par_ready = 1'b1;
        bus.child_data[0 +: 8] = 8'h10;
        bus.child_data[8 +: 8] = 8'h03;
        bus.child_parity = 5'b00001;
        bus.child_valid  = 5'b00001;
        tick();
        total++; if (bus.par_parity !== 1'b1) begin bad++; $display("FAIL par_bit0 got=%b exp=1", bus.par_parity); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_good got=%b exp=0", parity_err); end
        bus.child_parity = 5'b00000;
        bus.child_valid  = 5'b00010;
        tick();
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err_set got=%b exp=1", parity_err); end
        total++; if (bus.par_parity !== 1'b1) begin bad++; $display("FAIL par_bit1 got=%b exp=1", bus.par_parity); end
        bus.child_valid = 5'b00000;
        repeat (3) tick();
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err_sticky got=%b exp=1", parity_err); end
        rst_n = 1'b0;
        #1;
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_reset got=%b exp=0", parity_err); end
        tick();
        rst_n = 1'b1;
        #1;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.child_valid     = '0;
        bus.par_ready       = 1'b0;
        bus_sat.child_valid = '0;
        bus_sat.par_ready   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.child_data[k*8 +: 8]     = 8'(8'h10 + k);
            bus_sat.child_data[k*8 +: 8] = 8'(8'h50 + k);
        end
`ifdef HIER_COLLECT_PARITY_EN
        bus.child_parity     = '0;
        bus_sat.child_parity = '0;
`endif
        test_reset();
        test_fairness();
        test_backpressure();
        test_wrap_skip();
        test_saturation();
`ifdef HIER_COLLECT_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hier_resp_collector.md
Name: hier_resp_collector

Overview:
- Fan-in counterpart to the root-module fan-out hierarchy: gathers responses from NUM_CHILD child instances and serializes them toward the parent.
- Children present valid/data beats. A round-robin arbiter grants one child per cycle.
- The granted beat is registered and tagged with its child index, then offered to the parent on a valid/ready interface.
- The block keeps a saturating count of forwarded responses.

Parameters:
- NUM_CHILD, 5, number of child response ports (2..16).
- DATA_W, 8, response payload width.
- IDX_W, 3, width of child index tag; must satisfy 2**IDX_W >= NUM_CHILD.
- CNT_W, 16, width of forwarded-response counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- child_valid  in  NUM_CHILD  per-child response valid.
- child_data  in  NUM_CHILD*DATA_W  packed payloads; child k occupies bits [k*DATA_W +: DATA_W].
- child_ready  out  NUM_CHILD  per-child accept; at most one bit high.
- par_valid  out  1  response available to parent.
- par_data  out  DATA_W  registered payload.
- par_idx  out  IDX_W  index of the child that produced par_data.
- par_ready  in  1  parent accepts when high with par_valid.
- resp_count  out  CNT_W  number of parent handshakes completed; saturates.
- busy  out  1  high when par_valid or any child_valid is high.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert handled externally):
  - par_valid=0, par_data=0, par_idx=0, resp_count=0, rr_ptr=0.
  - child_ready=0 while rst_n low.
- Output register states:
  - EMPTY (par_valid=0) and FULL (par_valid=1).
  - load_en = EMPTY or (FULL and par_ready).
- Arbitration, combinational:
  - Scan children rr_ptr, rr_ptr+1, ... wrapping modulo NUM_CHILD; the first with child_valid=1 is the grant g.
  - child_ready[g]=1 only if load_en; all other bits 0.
  - No valid child: child_ready=0.
- Load: on a cycle with load_en and a grant:
  - register child_data[g] into par_data and g into par_idx;
  - par_valid=1 next cycle;
  - rr_ptr <= (g+1) mod NUM_CHILD (wrap from NUM_CHILD-1 to 0).
- Drain: on a cycle with par_valid and par_ready and no grant, par_valid <= 0.
- Simultaneous drain and load in FULL: new beat replaces the old one, par_valid stays 1. Full throughput is one response per cycle.
- Latency: child handshake at cycle N -> par_valid with that data at cycle N+1.
- Backpressure: par_valid=1 and par_ready=0 -> par_data/par_idx held stable, all child_ready=0.
- rr_ptr changes only on a grant. No child waits more than NUM_CHILD grants while continuously valid.
- resp_count increments on each par_valid & par_ready cycle and holds at 2**CNT_W-1 (no wrap).
- Reset mid-transfer: a pending par beat is discarded; a child beat presented in the same cycle is not accepted.
- Child contract: a child holds child_valid and data until child_ready. The block does not check this.

Optional Feature:
- Macro HIER_COLLECT_PARITY_EN.
- When defined:
  - extra output par_parity (1 bit) = XOR of par_data and par_idx, registered with them, reset 0;
  - extra input child_parity (NUM_CHILD bits);
  - on each load, if the child's parity bit mismatches the XOR of its data and index, a sticky output parity_err goes high until reset.
- When undefined: none of these ports or logic exist; behaviour otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with all children valid -> child_ready=0, par_valid=0, resp_count=0; release -> first grant is child 0.
- Fairness: all 5 children valid continuously, par_ready=1 -> par_idx sequence 0,1,2,3,4,0 on consecutive cycles; resp_count=6 after 6 beats.
- Backpressure: child 2 sends 0xA5, par_ready=0 for 4 cycles -> par_data=0xA5 and par_idx=2 stable; child_ready=0 throughout; single handshake on release.
- Wrap/skip: rr_ptr=4, only children 1 and 3 valid -> grant order 1 then 3; rr_ptr ends at 4.
- Saturation: CNT_W=3, 10 handshakes -> resp_count stops at 7.
- Parity (macro on): child 1 sends data 0x03 with a wrong parity bit -> parity_err=1 the cycle after load and stays high until rst_n=0.
